// File: rtl/mem_arbiter.sv
// Two-requester (IFU fetch / LSU load-store) arbiter onto a single memory command port.
// Define MEM_ARB_RR_EN for round-robin on conflict; default is fixed LSU-over-IFU priority.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0] ifu_addr,
  output logic                  ifu_resp_valid,
  output logic [DATA_WIDTH-1:0] ifu_rdata,

  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic                  lsu_wen,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  input  logic [1:0]            lsu_wbyte,
  output logic                  lsu_resp_valid,
  output logic [DATA_WIDTH-1:0] lsu_rdata,

  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  output logic                  mem_ren,
  output logic [1:0]            mem_wbyte,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  localparam logic IdIfu = 1'b0;
  localparam logic IdLsu = 1'b1;

  state_e                  state_q, state_d;
  logic                    id_q, id_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    wen_q, wen_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [1:0]              wbyte_q, wbyte_d;

  logic                    gnt_ifu, gnt_lsu;
  logic                    handshake;

`ifdef MEM_ARB_RR_EN
  logic                    last_q, last_d;
`endif

  // Grant only in IDLE and never while reset is held, so readys are 0 during reset.
  always_comb begin
    gnt_ifu = 1'b0;
    gnt_lsu = 1'b0;
    if (rst && (state_q == StIdle)) begin
      if (ifu_req_valid && lsu_req_valid) begin
`ifdef MEM_ARB_RR_EN
        gnt_ifu = (last_q == IdLsu);
        gnt_lsu = (last_q == IdIfu);
`else
        gnt_lsu = 1'b1;
`endif
      end else begin
        gnt_ifu = ifu_req_valid;
        gnt_lsu = lsu_req_valid;
      end
    end
  end

  assign ifu_req_ready = gnt_ifu;
  assign lsu_req_ready = gnt_lsu;
  assign handshake     = gnt_ifu | gnt_lsu;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wbyte_d = wbyte_q;
    case (state_q)
      StIdle: begin
        if (handshake) begin
          state_d = StAccess;
          if (gnt_lsu) begin
            id_d    = IdLsu;
            addr_d  = lsu_addr;
            wen_d   = lsu_wen;
            wdata_d = lsu_wdata;
            wbyte_d = lsu_wbyte;
          end else begin
            // Fetch is a read-only full-word access.
            id_d    = IdIfu;
            addr_d  = ifu_addr;
            wen_d   = 1'b0;
            wdata_d = '0;
            wbyte_d = 2'b11;
          end
        end
      end
      StAccess: state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

`ifdef MEM_ARB_RR_EN
  always_comb begin
    last_d = last_q;
    if (handshake) begin
      last_d = gnt_lsu ? IdLsu : IdIfu;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      id_q    <= IdIfu;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wbyte_q <= 2'b00;
`ifdef MEM_ARB_RR_EN
      last_q  <= IdLsu;
`endif
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wbyte_q <= wbyte_d;
`ifdef MEM_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  always_comb begin
    mem_addr       = '0;
    mem_wdata      = '0;
    mem_wen        = 1'b0;
    mem_ren        = 1'b0;
    mem_wbyte      = 2'b00;
    ifu_resp_valid = 1'b0;
    ifu_rdata      = '0;
    lsu_resp_valid = 1'b0;
    lsu_rdata      = '0;
    case (state_q)
      StAccess: begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_wbyte = wbyte_q;
        mem_wen   = wen_q & (id_q == IdLsu);
        mem_ren   = ~mem_wen;
      end
      StResp: begin
        // Memory read data arrives the cycle after mem_ren, i.e. now.
        if (id_q == IdLsu) begin
          lsu_resp_valid = 1'b1;
          lsu_rdata      = wen_q ? '0 : mem_rdata;
        end else begin
          ifu_resp_valid = 1'b1;
          ifu_rdata      = mem_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level reference model plus directed literals.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ifu_req_valid = 1'b0;
  logic          ifu_req_ready;
  logic [AW-1:0] ifu_addr = '0;
  logic          ifu_resp_valid;
  logic [DW-1:0] ifu_rdata;
  logic          lsu_req_valid = 1'b0;
  logic          lsu_req_ready;
  logic [AW-1:0] lsu_addr = '0;
  logic          lsu_wen = 1'b0;
  logic [DW-1:0] lsu_wdata = '0;
  logic [1:0]    lsu_wbyte = 2'b00;
  logic          lsu_resp_valid;
  logic [DW-1:0] lsu_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wen;
  logic          mem_ren;
  logic [1:0]    mem_wbyte;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_addr       (ifu_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_rdata      (ifu_rdata),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_addr       (lsu_addr),
    .lsu_wen        (lsu_wen),
    .lsu_wdata      (lsu_wdata),
    .lsu_wbyte      (lsu_wbyte),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_rdata      (lsu_rdata),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wen        (mem_wen),
    .mem_ren        (mem_ren),
    .mem_wbyte      (mem_wbyte),
    .mem_rdata      (mem_rdata)
  );

  // Small word memory behind the arbiter: registered read, full-word write.
  logic [DW-1:0] tbmem [64] = '{default: 32'h0};
  always @(posedge clk) begin
    if (mem_wen) tbmem[mem_addr[7:2]] <= mem_wdata;
    if (mem_ren) mem_rdata <= tbmem[mem_addr[7:2]];
  end

  int checks = 0;
  int failures = 0;

  // Reference model: one transaction in flight, command at handshake+1, response at +2.
  int            cyc = 0;
  int            hs_cyc = -100;
  bit            m_id;
  bit            m_wen;
  bit            m_last = 1'b1;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [1:0]    m_wbyte;
  logic [DW-1:0] ref_mem [64];

  int d_who[$];
  int d_cyc[$];
  int exp_who[4];

  bit            s_rst, s_iv, s_lv, s_lw;
  logic [AW-1:0] s_ia, s_la;
  logic [DW-1:0] s_ld;
  logic [1:0]    s_lb;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic step();
    int            age;
    int            w;
    logic          e_ir, e_lr, e_ren, e_wen, e_iv, e_lv;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_irdata, e_lrdata;
    logic [1:0]    e_wb;
    @(negedge clk);
    rst           = s_rst;
    ifu_req_valid = s_iv;
    ifu_addr      = s_ia;
    lsu_req_valid = s_lv;
    lsu_addr      = s_la;
    lsu_wen       = s_lw;
    lsu_wdata     = s_ld;
    lsu_wbyte     = s_lb;
    #3;
    e_ir = 1'b0; e_lr = 1'b0; e_ren = 1'b0; e_wen = 1'b0; e_iv = 1'b0; e_lv = 1'b0;
    e_addr = '0; e_wdata = '0; e_irdata = '0; e_lrdata = '0; e_wb = 2'b00;
    age = cyc - hs_cyc;
    if (!s_rst) begin
      hs_cyc = -100;
      m_last = 1'b1;
    end else if (age >= 3) begin
      w = -1;
      if (s_iv && s_lv) begin
`ifdef MEM_ARB_RR_EN
        w = m_last ? 0 : 1;
`else
        w = 1;
`endif
      end else if (s_iv) begin
        w = 0;
      end else if (s_lv) begin
        w = 1;
      end
      if (w >= 0) begin
        e_ir    = (w == 0);
        e_lr    = (w == 1);
        hs_cyc  = cyc;
        m_id    = (w == 1);
        m_last  = (w == 1);
        m_addr  = (w == 1) ? s_la : s_ia;
        m_wen   = (w == 1) ? s_lw : 1'b0;
        m_wdata = (w == 1) ? s_ld : '0;
        m_wbyte = (w == 1) ? s_lb : 2'b11;
      end
    end else if (age == 1) begin
      e_addr  = m_addr;
      e_wdata = m_wdata;
      e_wb    = m_wbyte;
      e_wen   = m_wen;
      e_ren   = !m_wen;
      if (m_wen) ref_mem[m_addr[7:2]] = m_wdata;
    end else if (age == 2) begin
      if (m_id) begin
        e_lv     = 1'b1;
        e_lrdata = m_wen ? '0 : ref_mem[m_addr[7:2]];
      end else begin
        e_iv     = 1'b1;
        e_irdata = ref_mem[m_addr[7:2]];
      end
    end
    chk("ready", 64'({ifu_req_ready, lsu_req_ready}), 64'({e_ir, e_lr}));
    chk("mem_ctl", 64'({mem_ren, mem_wen, mem_wbyte}), 64'({e_ren, e_wen, e_wb}));
    chk("mem_addr", 64'(mem_addr), 64'(e_addr));
    chk("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
    chk("ifu_resp", 64'({ifu_resp_valid, ifu_rdata}), 64'({e_iv, e_irdata}));
    chk("lsu_resp", 64'({lsu_resp_valid, lsu_rdata}), 64'({e_lv, e_lrdata}));
    if (ifu_req_valid && ifu_req_ready) begin d_who.push_back(0); d_cyc.push_back(cyc); end
    if (lsu_req_valid && lsu_req_ready) begin d_who.push_back(1); d_cyc.push_back(cyc); end
    cyc++;
  endtask

  task automatic quiet(input int n);
    s_iv = 1'b0;
    s_lv = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
`ifdef MEM_ARB_RR_EN
    exp_who = '{0, 1, 0, 1};
`else
    exp_who = '{1, 1, 1, 1};
`endif
    s_ia = '0; s_la = '0; s_lw = 1'b0; s_ld = '0; s_lb = 2'b00;

    // Held in reset with both requesting: nothing may be granted or issued.
    s_rst = 1'b0; s_iv = 1'b1; s_lv = 1'b1;
    step();
    step();
    chk("reset_ifu_ready", 64'(ifu_req_ready), 64'(0));
    chk("reset_mem_cmd", 64'({mem_ren, mem_wen}), 64'(0));
    s_rst = 1'b1;
    quiet(1);

    // Seed 0x100 with a store, then fetch it back.
    s_lv = 1'b1; s_la = 32'h100; s_lw = 1'b1; s_ld = 32'hDEADBEEF; s_lb = 2'b11;
    step();
    quiet(3);
    s_iv = 1'b1; s_ia = 32'h100;
    step();
    chk("fetch_ready", 64'(ifu_req_ready), 64'(1));
    s_iv = 1'b0;
    step();
    chk("fetch_cmd", 64'({mem_ren, mem_wen, mem_addr}), 64'({2'b10, 32'h100}));
    step();
    chk("fetch_resp", 64'({ifu_resp_valid, ifu_rdata}), 64'({1'b1, 32'hDEADBEEF}));
    quiet(1);

    // Half-word store.
    s_lv = 1'b1; s_la = 32'h200; s_lw = 1'b1; s_ld = 32'h12345678; s_lb = 2'b01;
    step();
    s_lv = 1'b0;
    step();
    chk("store_cmd", 64'({mem_wen, mem_ren, mem_wbyte}), 64'({2'b10, 2'b01}));
    chk("store_wdata", 64'(mem_wdata), 64'(32'h12345678));
    step();
    chk("store_resp", 64'({lsu_resp_valid, lsu_rdata}), 64'({1'b1, 32'h0}));
    quiet(1);

    // LSU arrives while IFU transaction is in flight: waits until handshake+3.
    s_iv = 1'b1; s_ia = 32'h40; s_lw = 1'b0; s_la = 32'h100;
    step();
    s_iv = 1'b0; s_lv = 1'b1;
    step();
    chk("blocked_ready_a", 64'(lsu_req_ready), 64'(0));
    step();
    chk("blocked_ready_b", 64'(lsu_req_ready), 64'(0));
    step();
    chk("blocked_ready_n3", 64'(lsu_req_ready), 64'(1));
    quiet(3);

    // Fresh reset, then both requesting continuously for four grants.
    s_rst = 1'b0;
    quiet(1);
    s_rst = 1'b1;
    d_who.delete();
    d_cyc.delete();
    s_iv = 1'b1; s_lv = 1'b1; s_ia = 32'h8; s_la = 32'hC; s_lw = 1'b0;
    for (int i = 0; i < 12; i++) step();
    quiet(2);
    chk("conflict_grants", 64'(d_who.size()), 64'(4));
    for (int i = 0; i < 4; i++) begin
      if (i < d_who.size()) begin
        chk("conflict_winner", 64'(d_who[i]), 64'(exp_who[i]));
        chk("conflict_spacing", 64'(d_cyc[i] - d_cyc[0]), 64'(3 * i));
      end
    end

    // Reset pulse during an LSU load's memory cycle.
    s_lv = 1'b1; s_la = 32'h200; s_lw = 1'b0;
    step();
    s_lv = 1'b0;
    step();
    chk("load_cmd_live", 64'(mem_ren), 64'(1));
    rst = 1'b0;
    #1;
    chk("load_cmd_killed", 64'({mem_ren, mem_wen, mem_addr}), 64'(0));
    hs_cyc = -100;
    m_last = 1'b1;
    s_rst = 1'b0;
    step();
    chk("killed_no_resp", 64'(lsu_resp_valid), 64'(0));
    s_rst = 1'b1; s_iv = 1'b1; s_ia = 32'h10;
    step();
    chk("idle_after_reset", 64'(ifu_req_ready), 64'(1));
    quiet(3);

    for (int i = 0; i < 800; i++) begin
      s_rst = ($urandom_range(0, 99) != 0);
      s_iv  = ($urandom_range(0, 2) != 0);
      s_lv  = ($urandom_range(0, 2) != 0);
      s_ia  = $urandom;
      s_la  = $urandom;
      s_lw  = 1'($urandom_range(0, 1));
      s_ld  = $urandom;
      s_lb  = 2'($urandom_range(0, 3));
      step();
    end
    s_rst = 1'b1;
    quiet(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning byte-address width on all ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning data word width on all ports.
REQ-003 SHALL have clk  input  1  sole clock, all state updates on its rising edge.
REQ-004 SHALL have rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 SHALL have ifu_req_valid  input  1, ifu_req_ready  output  1, ifu_addr  input  ADDR_WIDTH  instruction-fetch read request.
REQ-006 SHALL have ifu_resp_valid  output  1, ifu_rdata  output  DATA_WIDTH  fetch response.
REQ-007 SHALL have lsu_req_valid  input  1, lsu_req_ready  output  1, lsu_addr  input  ADDR_WIDTH, lsu_wen  input  1 (1 = store), lsu_wdata  input  DATA_WIDTH, lsu_wbyte  input  2 (00/10 = 1 byte, 01 = 2 bytes, 11 = 4 bytes)  load/store request.
REQ-008 SHALL have lsu_resp_valid  output  1, lsu_rdata  output  DATA_WIDTH  load data or store ack.
REQ-009 SHALL have mem_addr  output  ADDR_WIDTH, mem_wdata  output  DATA_WIDTH, mem_wen  output  1, mem_ren  output  1, mem_wbyte  output  2  memory command port.
REQ-010 SHALL have mem_rdata  input  DATA_WIDTH  memory read data, valid the cycle after mem_ren is sampled.

Function
REQ-011 SHALL implement FSM states IDLE, ACCESS, RESP; transitions IDLE->ACCESS on handshake, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
REQ-012 SHALL, in IDLE only, combinationally assert req_ready to exactly one requester whose req_valid is 1 (the grant winner); both readys are 0 in ACCESS and RESP.
REQ-013 SHALL complete a handshake when req_valid & req_ready are both 1, latching winner id, addr, wen, wdata, wbyte into internal registers.
REQ-014 SHALL, in ACCESS, drive mem_addr/mem_wdata/mem_wbyte from latched registers and assert mem_ren (load/fetch) or mem_wen (store) for exactly one cycle; mem_ren and mem_wen never both 1.
REQ-015 SHALL drive all mem_* outputs to 0 outside ACCESS.
REQ-016 SHALL force mem_wen 0 for IFU transactions (fetch is read-only, wbyte 11 driven).
REQ-017 SHALL, in RESP, assert resp_valid of the granted requester for exactly one cycle, rdata = mem_rdata for reads, rdata = 0 for stores; non-granted resp_valid and rdata = 0.
REQ-018 SHALL give fixed latency: handshake cycle N, memory command N+1, resp_valid N+2; next grant no earlier than N+3.
REQ-019 SHALL resolve simultaneous valids per the Configuration policy; a lone valid wins immediately.
REQ-020 SHALL ignore requester input changes after handshake until RESP completes.
REQ-021 SHALL accept back-to-back requests from the same requester with no idle cycles beyond REQ-018.

Reset
REQ-022 SHALL, on rst=0 at any time including mid-ACCESS or RESP, enter IDLE asynchronously, drop the in-flight transaction, and drive all outputs 0.
REQ-023 SHALL reset latched registers to 0 and the last-grant register to LSU.
REQ-024 SHALL not issue any mem_wen or mem_ren while rst=0, leaving the memory's own initialisation undisturbed.

Configuration
REQ-025 SHALL, with macro MEM_ARB_RR_EN defined, use round-robin arbitration: on conflict the requester not granted last wins; last-grant updates on every handshake.
REQ-026 SHALL, without MEM_ARB_RR_EN, use fixed priority LSU over IFU on conflict; last-grant register absent.

Verification
REQ-027 SHALL cover: IFU read addr 0x100, mem returns 0xDEADBEEF -> mem_ren=1 at N+1 with mem_addr=0x100, ifu_resp_valid=1 with ifu_rdata=0xDEADBEEF at N+2.
REQ-028 SHALL cover: LSU store addr 0x200, wdata 0x12345678, wbyte 01 -> mem_wen=1, mem_wbyte=01, mem_ren=0 at N+1; lsu_resp_valid=1, lsu_rdata=0 at N+2.
REQ-029 SHALL cover: both valid continuously for 4 grants -> without macro LSU,LSU,LSU,LSU; with MEM_ARB_RR_EN IFU,LSU,IFU,LSU, grants 3 cycles apart.
REQ-030 SHALL cover: rst=0 pulsed during ACCESS of LSU load -> mem_ren drops to 0 immediately, no lsu_resp_valid, FSM in IDLE after release.
REQ-031 SHALL cover: LSU valid asserted during IFU ACCESS -> lsu_req_ready stays 0 until IDLE, then handshake at N+3.
